// File: rtl/reorder_buffer_if.sv
// ---------------------------------------------------------------------------
// reorder_buffer_if
// Purpose : bundles the allocate, complete and in-order output handshakes of
//           the reorder buffer into one port.
// Signals :
//   alloc_v / alloc_rdy / alloc_tag      - tag allocation handshake
//   cmpl_v / cmpl_tag / cmpl_din         - out-of-order completion write
//   dout / dout_v / dout_rdy             - in-order output, valid/ready
//   occupancy                            - allocated entries not yet popped
//   err                                  - sticky protocol error
// Modports: slave = the reorder buffer, master = issuer/consumer side.
// ---------------------------------------------------------------------------
interface reorder_buffer_if #(
  parameter int W_DIN    = 8,
  parameter int LOG2SIZE = 4
);
  logic                alloc_v;
  logic                alloc_rdy;
  logic [LOG2SIZE-1:0] alloc_tag;
  logic                cmpl_v;
  logic [LOG2SIZE-1:0] cmpl_tag;
  logic [W_DIN-1:0]    cmpl_din;
  logic [W_DIN-1:0]    dout;
  logic                dout_v;
  logic                dout_rdy;
  logic [LOG2SIZE:0]   occupancy;
  logic                err;

  modport slave (
    input  alloc_v, cmpl_v, cmpl_tag, cmpl_din, dout_rdy,
    output alloc_rdy, alloc_tag, dout, dout_v, occupancy, err
  );

  modport master (
    output alloc_v, cmpl_v, cmpl_tag, cmpl_din, dout_rdy,
    input  alloc_rdy, alloc_tag, dout, dout_v, occupancy, err
  );
endinterface

// File: rtl/reorder_buffer.sv
// ---------------------------------------------------------------------------
// reorder_buffer
// Purpose : in-order completion buffer with sequential tag allocation.
//           Tags are handed out in order, completions come back out of order
//           with data, and data leaves strictly in allocation order through a
//           registered valid/ready output stage that honours backpressure.
// Ports   :
//   clk    - rising-edge clock
//   rst    - asynchronous active-high reset
//   io_rob - reorder_buffer_if.slave (alloc, completion, output, status)
// Parameters:
//   W_DIN    - data width
//   LOG2SIZE - log2 of entry count
// Optional feature macro: ROB_ERR_CHECK_EN
//   defined   : completions to unallocated or already-done tags are dropped,
//               and they (or alloc_v while !alloc_rdy) set a sticky err.
//   undefined : every completion writes, err is tied low.
// ---------------------------------------------------------------------------
module reorder_buffer #(
  parameter int W_DIN    = 8,
  parameter int LOG2SIZE = 4
) (
  input  logic            clk,
  input  logic            rst,
  reorder_buffer_if.slave io_rob
);

  localparam int                SIZE     = 1 << LOG2SIZE;
  localparam logic [LOG2SIZE:0] PTR_ONE  = {{LOG2SIZE{1'b0}}, 1'b1};
  localparam logic [LOG2SIZE:0] PTR_FULL = {1'b1, {LOG2SIZE{1'b0}}};

  // Pointers carry one extra MSB as wrap phase so full and empty differ.
  logic [LOG2SIZE:0]   r_wr_ptr;
  logic [LOG2SIZE:0]   r_rd_ptr;
  logic [SIZE-1:0]     r_done;
  logic [W_DIN-1:0]    r_mem [SIZE];
  logic [W_DIN-1:0]    r_dout;
  logic                r_dout_v;
  logic                r_alloc_rdy;

  logic [LOG2SIZE-1:0] w_head;
  logic [LOG2SIZE:0]   w_occ;
  logic                w_alloc;
  logic                w_pop;
  logic                w_cmpl_we;
  logic [LOG2SIZE:0]   w_wr_next;
  logic [LOG2SIZE:0]   w_rd_next;

  assign w_head  = r_rd_ptr[LOG2SIZE-1:0];
  assign w_occ   = r_wr_ptr - r_rd_ptr;
  assign w_alloc = io_rob.alloc_v & r_alloc_rdy;
  // Pop uses the registered done bit, so a completion landing on the head
  // this cycle is only seen next cycle. The occupancy guard keeps a stray
  // done bit from popping an unallocated slot when checks are compiled out.
  assign w_pop   = (w_occ != '0) & r_done[w_head] & (~r_dout_v | io_rob.dout_rdy);

  assign w_wr_next = w_alloc ? (r_wr_ptr + PTR_ONE) : r_wr_ptr;
  assign w_rd_next = w_pop   ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;

`ifdef ROB_ERR_CHECK_EN
  logic [LOG2SIZE-1:0] w_tag_off;
  logic                w_tag_live;
  logic                w_err_set;
  logic                r_err;

  // A tag is live when its distance from the head is below occupancy.
  assign w_tag_off  = io_rob.cmpl_tag - w_head;
  assign w_tag_live = ({1'b0, w_tag_off} < w_occ);
  assign w_cmpl_we  = io_rob.cmpl_v & w_tag_live & ~r_done[io_rob.cmpl_tag];
  assign w_err_set  = (io_rob.cmpl_v & ~w_cmpl_we) | (io_rob.alloc_v & ~r_alloc_rdy);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end

  assign io_rob.err = r_err;
`else
  assign w_cmpl_we  = io_rob.cmpl_v;
  assign io_rob.err = 1'b0;
`endif

  // Pointers, output stage and registered alloc_rdy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_dout      <= '0;
      r_dout_v    <= 1'b0;
      r_alloc_rdy <= 1'b1;
    end else begin
      r_wr_ptr    <= w_wr_next;
      r_rd_ptr    <= w_rd_next;
      // Computed from next-state pointers so a pop frees space one cycle on.
      r_alloc_rdy <= ((w_wr_next - w_rd_next) != PTR_FULL);
      if (w_pop) begin
        r_dout   <= r_mem[w_head];
        r_dout_v <= 1'b1;
      end else if (io_rob.dout_rdy) begin
        r_dout_v <= 1'b0;
      end
    end
  end

  // Data RAM: not reset, written on accepted completions.
  always_ff @(posedge clk) begin
    if (w_cmpl_we) begin
      r_mem[io_rob.cmpl_tag] <= io_rob.cmpl_din;
    end
  end

  // Per-entry done bits: set by completion, cleared when the entry pops.
  genvar gi;
  generate
    for (gi = 0; gi < SIZE; gi++) begin : g_done
      localparam logic [LOG2SIZE-1:0] IDX = LOG2SIZE'(gi);
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_done[gi] <= 1'b0;
        end else if (w_cmpl_we && (io_rob.cmpl_tag == IDX)) begin
          r_done[gi] <= 1'b1;
        end else if (w_pop && (w_head == IDX)) begin
          r_done[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  assign io_rob.alloc_rdy = r_alloc_rdy;
  assign io_rob.alloc_tag = r_wr_ptr[LOG2SIZE-1:0];
  assign io_rob.dout      = r_dout;
  assign io_rob.dout_v    = r_dout_v;
  assign io_rob.occupancy = w_occ;

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;
  int   perm [8];
  int   base_tag;

  reorder_buffer_if #(.W_DIN(8), .LOG2SIZE(4)) bus ();

  reorder_buffer #(.W_DIN(8), .LOG2SIZE(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_rob (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // With dout_rdy held high every cycle with dout_v is a fresh beat.
  task automatic tick_mon();
    tick();
    if (bus.dout_v === 1'b1) begin
      chk("wrap_seq", 32'(bus.dout), 32'(8'h80 + n_out));
      n_out++;
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.alloc_v  = 1'b0;
    bus.cmpl_v   = 1'b0;
    bus.cmpl_tag = '0;
    bus.cmpl_din = '0;
    bus.dout_rdy = 1'b0;
    #3;
    chk("rst_dout_v",    32'(bus.dout_v),    0);
    chk("rst_dout",      32'(bus.dout),      0);
    chk("rst_occ",       32'(bus.occupancy), 0);
    chk("rst_err",       32'(bus.err),       0);
    chk("rst_alloc_rdy", 32'(bus.alloc_rdy), 1);
    chk("rst_alloc_tag", 32'(bus.alloc_tag), 0);
    #10;
    rst = 1'b0;
    tick();

    // In-order fill of all 16 entries
    bus.alloc_v = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("fill_tag", 32'(bus.alloc_tag), i);
      tick();
    end
    bus.alloc_v = 1'b0;
    chk("full_alloc_rdy", 32'(bus.alloc_rdy), 0);
    chk("full_occ",       32'(bus.occupancy), 16);
    bus.dout_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.cmpl_v   = 1'b1;
      bus.cmpl_tag = 4'(i);
      bus.cmpl_din = 8'(8'h10 + i);
      tick();
      if (i == 0) begin
        chk("fill_first_v", 32'(bus.dout_v), 0);
        chk("fill_occ0",    32'(bus.occupancy), 16);
      end else begin
        chk("fill_dout",   32'(bus.dout),      32'(8'h10 + i - 1));
        chk("fill_dout_v", 32'(bus.dout_v),    1);
        chk("fill_occ",    32'(bus.occupancy), 16 - i);
      end
    end
    bus.cmpl_v = 1'b0;
    tick();
    chk("fill_last",      32'(bus.dout),      8'h1F);
    chk("fill_last_v",    32'(bus.dout_v),    1);
    chk("fill_occ_end",   32'(bus.occupancy), 0);
    chk("fill_alloc_rdy", 32'(bus.alloc_rdy), 1);
    tick();
    chk("drain_v",    32'(bus.dout_v), 0);
    chk("drain_hold", 32'(bus.dout),   8'h1F);

    // Reverse completion order, tags 0..7
    bus.alloc_v = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("rev_tag", 32'(bus.alloc_tag), i);
      tick();
    end
    bus.alloc_v = 1'b0;
    for (int t = 7; t >= 1; t--) begin
      bus.cmpl_v   = 1'b1;
      bus.cmpl_tag = 4'(t);
      bus.cmpl_din = 8'(8'h40 + t);
      tick();
      chk("rev_wait_v", 32'(bus.dout_v), 0);
    end
    bus.cmpl_tag = 4'd0;
    bus.cmpl_din = 8'h40;
    tick();
    bus.cmpl_v = 1'b0;
    chk("rev_head_edge_v", 32'(bus.dout_v), 0);
    for (int t = 0; t < 8; t++) begin
      tick();
      chk("rev_v",    32'(bus.dout_v), 1);
      chk("rev_dout", 32'(bus.dout),   32'(8'h40 + t));
    end
    tick();
    chk("rev_end_v",   32'(bus.dout_v),    0);
    chk("rev_end_occ", 32'(bus.occupancy), 0);

    // Backpressure: tags 8..11 with consumer stalled
    bus.dout_rdy = 1'b0;
    bus.alloc_v  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_tag", 32'(bus.alloc_tag), 8 + i);
      tick();
    end
    bus.alloc_v = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.cmpl_v   = 1'b1;
      bus.cmpl_tag = 4'(8 + i);
      bus.cmpl_din = 8'(8'h60 + i);
      tick();
    end
    bus.cmpl_v = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_dout",      32'(bus.dout),      8'h60);
      chk("bp_dout_v",    32'(bus.dout_v),    1);
      chk("bp_alloc_rdy", 32'(bus.alloc_rdy), 1);
      chk("bp_occ",       32'(bus.occupancy), 3);
    end
    bus.dout_rdy = 1'b1;
    for (int t = 1; t < 4; t++) begin
      tick();
      chk("bp_rel_dout", 32'(bus.dout),   32'(8'h60 + t));
      chk("bp_rel_v",    32'(bus.dout_v), 1);
    end
    chk("bp_rel_occ", 32'(bus.occupancy), 0);
    tick();
    chk("bp_end_v", 32'(bus.dout_v), 0);

    // Wrap: 5 windows of 8, completions shuffled within each window
    for (int w = 0; w < 5; w++) begin
      base_tag    = (12 + w * 8) % 16;
      bus.alloc_v = 1'b1;
      for (int j = 0; j < 8; j++) begin
        chk("wrap_tag", 32'(bus.alloc_tag), (base_tag + j) % 16);
        tick_mon();
      end
      bus.alloc_v = 1'b0;
      for (int i = 0; i < 8; i++) perm[i] = i;
      for (int i = 7; i > 0; i--) begin
        int j;
        int tmp;
        j       = int'($urandom_range(i, 0));
        tmp     = perm[i];
        perm[i] = perm[j];
        perm[j] = tmp;
      end
      for (int k = 0; k < 8; k++) begin
        bus.cmpl_v   = 1'b1;
        bus.cmpl_tag = 4'((base_tag + perm[k]) % 16);
        bus.cmpl_din = 8'(8'h80 + w * 8 + perm[k]);
        tick_mon();
      end
      bus.cmpl_v = 1'b0;
    end
    for (int c = 0; c < 12; c++) tick_mon();
    chk("wrap_count",   n_out, 40);
    chk("wrap_tag_end", 32'(bus.alloc_tag), 4);
    chk("wrap_occ_end", 32'(bus.occupancy), 0);

    // Mid-traffic asynchronous reset with 5 entries in flight
    bus.dout_rdy = 1'b0;
    bus.alloc_v  = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    bus.alloc_v  = 1'b0;
    bus.cmpl_v   = 1'b1;
    bus.cmpl_tag = 4'd4;
    bus.cmpl_din = 8'hC4;
    tick();
    bus.cmpl_tag = 4'd5;
    bus.cmpl_din = 8'hC5;
    tick();
    bus.cmpl_v = 1'b0;
    chk("pre_rst_v",   32'(bus.dout_v),    1);
    chk("pre_rst_occ", 32'(bus.occupancy), 4);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_dout_v",    32'(bus.dout_v),    0);
    chk("arst_dout",      32'(bus.dout),      0);
    chk("arst_occ",       32'(bus.occupancy), 0);
    chk("arst_err",       32'(bus.err),       0);
    chk("arst_alloc_rdy", 32'(bus.alloc_rdy), 1);
    #2;
    rst          = 1'b0;
    bus.dout_rdy = 1'b1;
    tick();
    bus.alloc_v = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_tag", 32'(bus.alloc_tag), i);
      tick();
    end
    bus.alloc_v = 1'b0;
    chk("post_rst_occ", 32'(bus.occupancy), 3);

    // Stray completion to unallocated tag 9, then normal in-order output
    bus.cmpl_v   = 1'b1;
    bus.cmpl_tag = 4'd9;
    bus.cmpl_din = 8'hEE;
    tick();
`ifdef ROB_ERR_CHECK_EN
    chk("err_set", 32'(bus.err), 1);
`else
    chk("err_tied", 32'(bus.err), 0);
`endif
    for (int i = 0; i < 3; i++) begin
      bus.cmpl_tag = 4'(i);
      bus.cmpl_din = 8'(8'hA0 + i);
      tick();
      if (i > 0) chk("err_path_dout", 32'(bus.dout), 32'(8'hA0 + i - 1));
    end
    bus.cmpl_v = 1'b0;
    tick();
    chk("err_path_last", 32'(bus.dout),      8'hA2);
    chk("err_path_occ",  32'(bus.occupancy), 0);
    tick();
    chk("err_path_end_v", 32'(bus.dout_v), 0);
`ifdef ROB_ERR_CHECK_EN
    chk("err_sticky", 32'(bus.err), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
